// File: rtl/morse_sos_matcher.sv
// morse_sos_matcher
//   Collects dot/dash symbols into letters, classifies each closed letter as
//   S, O or other, and flags the S-O-S sequence over the last three letters.
//
// Parameters
//   GAP_TIMEOUT  idle cycles after the last dot/dash before an open letter is
//                force-closed (2..255)
//
// Ports
//   clk          system clock, posedge
//   rst_n        asynchronous active-low reset
//   symValid     one-cycle symbol strobe
//   symIn        2'b00 dot, 2'b11 dash, 2'b10 space, 2'b01 reserved (dropped)
//   letterValid  one-cycle pulse when a letter closes
//   letterCode   2'b01 S, 2'b10 O, 2'b11 other; holds between pulses
//   sosDetect    pulse with letterValid when the closing letter completes S-O-S
//   busy         high while a letter is open (COLLECT or EMIT)
//   sosCount     saturating count of sosDetect pulses
//
// Build option
//   SOS_COUNT_EN  when defined, sosCount is a live saturating counter;
//                 otherwise sosCount is tied to zero.

module morse_sos_matcher #(
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       symValid,
  input  logic [1:0] symIn,
  output logic       letterValid,
  output logic [1:0] letterCode,
  output logic       sosDetect,
  output logic       busy,
  output logic [7:0] sosCount
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;

  localparam logic [1:0] CODE_S     = 2'b01;
  localparam logic [1:0] CODE_O     = 2'b10;
  localparam logic [1:0] CODE_OTHER = 2'b11;
  localparam logic [7:0] EXPIRE_AT  = 8'(GAP_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [2:0] sym_cnt, sym_cnt_nxt;
  logic       overflow, overflow_nxt;
  // Only the last three symbols matter: S/O need exactly three, and any
  // longer letter is classified by the count alone.
  logic [2:0] sym_sr, sym_sr_nxt;
  logic [7:0] timer;
  logic [1:0] hist_old, hist_new;

  logic       sym_mark;
  logic       sym_space;
  logic       sym_ok;
  logic       expire;
  logic [1:0] cls;

  assign sym_mark  = symValid && (symIn == 2'b00 || symIn == 2'b11);
  assign sym_space = symValid && (symIn == 2'b10);
  assign sym_ok    = sym_mark || sym_space;
  // A real symbol on the expiry cycle takes priority; reserved codes do not.
  assign expire    = (state == COLLECT) && (timer == EXPIRE_AT) && !sym_ok;

  always_comb begin
    cls = CODE_OTHER;
    if (sym_cnt == 3'd3 && !overflow) begin
      if (sym_sr == 3'b000)      cls = CODE_S;
      else if (sym_sr == 3'b111) cls = CODE_O;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sym_cnt  <= '0;
      overflow <= 1'b0;
      sym_sr   <= '0;
    end else begin
      state    <= state_nxt;
      sym_cnt  <= sym_cnt_nxt;
      overflow <= overflow_nxt;
      sym_sr   <= sym_sr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sym_cnt_nxt  = sym_cnt;
    overflow_nxt = overflow;
    sym_sr_nxt   = sym_sr;
    case (state)
      IDLE, EMIT: begin
        // EMIT drops the closed letter and behaves like IDLE for new input,
        // so a dot/dash arriving during EMIT opens the next letter directly.
        state_nxt    = IDLE;
        sym_cnt_nxt  = '0;
        overflow_nxt = 1'b0;
        sym_sr_nxt   = '0;
        if (sym_mark) begin
          state_nxt   = COLLECT;
          sym_cnt_nxt = 3'd1;
          sym_sr_nxt  = {2'b00, symIn[0]};
        end
      end
      COLLECT: begin
        if (sym_mark) begin
          sym_sr_nxt = {sym_sr[1:0], symIn[0]};
          if (sym_cnt != 3'd5) sym_cnt_nxt = sym_cnt + 3'd1;
          if (sym_cnt >= 3'd4) overflow_nxt = 1'b1;
        end else if (sym_space || expire) begin
          state_nxt = EMIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (sym_mark) begin
      timer <= '0;
    end else if (state == COLLECT) begin
      timer <= timer + 8'd1;
    end else begin
      timer <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letterValid <= 1'b0;
      letterCode  <= '0;
      sosDetect   <= 1'b0;
      hist_old    <= '0;
      hist_new    <= '0;
    end else begin
      letterValid <= (state == EMIT);
      sosDetect   <= (state == EMIT) && (cls == CODE_S) &&
                     (hist_old == CODE_S) && (hist_new == CODE_O);
      if (state == EMIT) begin
        letterCode <= cls;
        hist_old   <= hist_new;
        hist_new   <= cls;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef SOS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sosCount <= '0;
    end else if (sosDetect && sosCount != 8'hFF) begin
      sosCount <= sosCount + 8'd1;
    end
  end
`else
  assign sosCount = '0;
`endif

endmodule

// File: tb/tb_morse_sos_matcher.sv
module tb_morse_sos_matcher;

  localparam int unsigned GAP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       symValid;
  logic [1:0] symIn;
  logic       letterValid;
  logic [1:0] letterCode;
  logic       sosDetect;
  logic       busy;
  logic [7:0] sosCount;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  morse_sos_matcher #(.GAP_TIMEOUT(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .symValid   (symValid),
    .symIn      (symIn),
    .letterValid(letterValid),
    .letterCode (letterCode),
    .sosDetect  (sosDetect),
    .busy       (busy),
    .sosCount   (sosCount)
  );

  // ---------------- reference model (letter-level, queue based) -------------
  bit         m_open, m_closing;
  int         m_idle;
  logic [1:0] m_syms[$];
  logic [1:0] m_closed[$];
  logic [1:0] m_hist[$];   // [0] older, [1] newer
  logic       m_lv, m_sos;
  logic [1:0] m_code;
  int         m_cnt;

  function automatic void model_reset();
    m_open = 0; m_closing = 0; m_idle = 0;
    m_syms.delete(); m_closed.delete();
    m_hist = '{2'b00, 2'b00};
    m_lv = 0; m_sos = 0; m_code = 2'b00; m_cnt = 0;
  endfunction

  function automatic logic [1:0] classify();
    int unsigned dots = 0, dashes = 0;
    foreach (m_closed[i]) if (m_closed[i] == 2'b00) dots++; else dashes++;
    if (m_closed.size() == 3 && dots == 3)   return 2'b01;
    if (m_closed.size() == 3 && dashes == 3) return 2'b10;
    return 2'b11;
  endfunction

  function automatic void model_close();
    m_closed = m_syms;
    m_syms.delete();
    m_open = 0;
    m_closing = 1;
  endfunction

  function automatic void model_step(input logic v, input logic [1:0] s);
    logic [1:0] c;
    bit accept;
    m_lv = 0; m_sos = 0;
    if (m_closing) begin
      c = classify();
      m_lv = 1; m_code = c;
      m_sos = (c == 2'b01) && (m_hist[0] == 2'b01) && (m_hist[1] == 2'b10);
      void'(m_hist.pop_front());
      m_hist.push_back(c);
      if (m_sos && m_cnt < 255) m_cnt++;
      m_closing = 0;
    end
    accept = v && (s == 2'b00 || s == 2'b11);
    if (m_open) begin
      if (accept) begin m_syms.push_back(s); m_idle = 0; end
      else if (v && s == 2'b10) model_close();
      else if (m_idle == int'(GAP) - 1) model_close();
      else m_idle++;
    end else if (accept) begin
      m_syms.delete(); m_syms.push_back(s); m_open = 1; m_idle = 0;
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] cnt;
`ifdef SOS_COUNT_EN
    cnt = 8'(m_cnt);
`else
    cnt = 8'h00;
`endif
    return {m_lv, m_code, m_sos, (m_open || m_closing), cnt};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {letterValid, letterCode, sosDetect, busy, sosCount};
  endfunction

  // ---------------- stimulus construction ----------------
  logic [2:0] stim[$];   // {valid, code}

  function automatic void push(input logic v, input logic [1:0] s);
    stim.push_back({v, s});
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 2'b00);
  endfunction

  // '.' dot, '-' dash, ' ' space, 'r' reserved, '_' idle; sp = cycles per char
  function automatic void add(input string str, input int sp);
    for (int i = 0; i < str.len(); i++) begin
      case (str[i])
        "." : push(1'b1, 2'b00);
        "-" : push(1'b1, 2'b11);
        " " : push(1'b1, 2'b10);
        "r" : push(1'b1, 2'b01);
        default: push(1'b0, 2'b00);
      endcase
      add_idle(sp - 1);
    end
  endfunction

  task automatic step(input logic v, input logic [1:0] s);
    symValid = v;
    symIn    = s;
    @(posedge clk);
    model_step(v, s);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; symValid = 1'b0; symIn = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 13'h0) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), 13'h0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b00);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL reset_idle step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sos_basic();
    logic [1:0] codes[$];
    int sos_n = 0, sos_at = -1;
    do_reset();
    stim.delete();
    add("... --- ... ", 2);
    add_idle(4);
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL sos_basic step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (letterValid) codes.push_back(letterCode);
      if (sosDetect) begin sos_n++; sos_at = codes.size(); end
    end
    checks++;
    if (codes.size() != 3 || codes[0] !== 2'b01 || codes[1] !== 2'b10 || codes[2] !== 2'b01) begin
      failures++; $display("FAIL sos_basic_codes got=%p exp=01,10,01", codes);
    end
    checks++;
    if (sos_n != 1 || sos_at != 3) begin
      failures++; $display("FAIL sos_basic_detect got=%0d@%0d exp=1@3", sos_n, sos_at);
    end
`ifdef SOS_COUNT_EN
    checks++;
    if (sosCount !== 8'd1) begin
      failures++; $display("FAIL sos_basic_count got=%0d exp=1", sosCount);
    end
`endif
  endtask

  task automatic test_overlap();
    int letter_n = 0;
    int sos_idx[$];
    do_reset();
    stim.delete();
    add("... --- ... --- ... ", 2);
    add("... .- --- ... ", 2);
    add_idle(4);
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL overlap step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (letterValid) letter_n++;
      if (sosDetect) sos_idx.push_back(letter_n);
    end
    checks++;
    if (letter_n != 9 || sos_idx.size() != 2 || sos_idx[0] != 3 || sos_idx[1] != 5) begin
      failures++; $display("FAIL overlap_detect got=%0d letters sos=%p exp=9 letters sos=3,5", letter_n, sos_idx);
    end
`ifdef SOS_COUNT_EN
    checks++;
    if (sosCount !== 8'd2) begin
      failures++; $display("FAIL overlap_count got=%0d exp=2", sosCount);
    end
`endif
  endtask

  task automatic test_overflow_spaces();
    logic [1:0] codes[$];
    int sos_n = 0, busy_hi = 0, lv_late = 0, base;
    do_reset();
    stim.delete();
    add("..... ", 2);
    add_idle(4);
    base = stim.size();
    add("   ", 2);
    add_idle(3);
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL overflow step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (letterValid) codes.push_back(letterCode);
      if (sosDetect) sos_n++;
      if (i >= base && busy) busy_hi++;
      if (i >= base && letterValid) lv_late++;
    end
    checks++;
    if (codes.size() != 1 || codes[0] !== 2'b11 || sos_n != 0) begin
      failures++; $display("FAIL overflow_code got=%p sos=%0d exp=11 sos=0", codes, sos_n);
    end
    checks++;
    if (busy_hi != 0 || lv_late != 0) begin
      failures++; $display("FAIL idle_spaces got busy=%0d lv=%0d exp busy=0 lv=0", busy_hi, lv_late);
    end
  endtask

  task automatic test_timeout();
    int lv_idx[$];
    logic [1:0] codes[$];
    int b2;
    do_reset();
    stim.delete();
    add("...", 1);
    add_idle(20);
    b2 = stim.size();
    add("...", 1);
    add_idle(7);
    add(".", 1);           // lands on the expiry cycle
    add_idle(20);
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL timeout step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (letterValid) begin lv_idx.push_back(i); codes.push_back(letterCode); end
    end
    checks++;
    if (lv_idx.size() != 2 || lv_idx[0] != 2 + 9 || lv_idx[1] != b2 + 10 + 9) begin
      failures++; $display("FAIL timeout_timing got=%p exp=%0d,%0d", lv_idx, 11, b2 + 19);
    end
    checks++;
    if (codes.size() != 2 || codes[0] !== 2'b01 || codes[1] !== 2'b11) begin
      failures++; $display("FAIL timeout_codes got=%p exp=01,11", codes);
    end
  endtask

  task automatic test_reserved();
    int lv_idx[$];
    logic [1:0] codes[$];
    do_reset();
    stim.delete();
    add(".r.r.rr_r__r", 1);
    add_idle(15);
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL reserved step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (letterValid) begin lv_idx.push_back(i); codes.push_back(letterCode); end
    end
    checks++;
    if (lv_idx.size() != 1 || lv_idx[0] != 4 + 9 || codes[0] !== 2'b01) begin
      failures++; $display("FAIL reserved_result got=%p codes=%p exp=13 code=01", lv_idx, codes);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] codes[$];
    int sos_n = 0;
    do_reset();
    stim.delete();
    add("... --- ... --- ... ", 1);
    add_idle(3);
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL back_to_back step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (letterValid) codes.push_back(letterCode);
      if (sosDetect) sos_n++;
    end
    checks++;
    if (codes.size() != 5 || codes[0] !== 2'b01 || codes[1] !== 2'b10 || codes[4] !== 2'b01 || sos_n != 2) begin
      failures++; $display("FAIL back_to_back_seq got=%p sos=%0d exp=01,10,01,10,01 sos=2", codes, sos_n);
    end
  endtask

  task automatic test_reset_mid_letter();
    int lv_n = 0, sos_n = 0;
    logic [1:0] code_seen;
    do_reset();
    stim.delete();
    add("... --- ..", 2);
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL reset_mid_pre step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL reset_mid_open got busy=%b exp=1", busy);
    end
    rst_n = 1'b0;
    symValid = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 13'h0) begin
      failures++; $display("FAIL reset_mid_async got=%h exp=%h", dut_vec(), 13'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    stim.delete();
    add("... ", 2);
    add_idle(4);
    code_seen = 2'b00;
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL reset_mid_post step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (letterValid) begin lv_n++; code_seen = letterCode; end
      if (sosDetect) sos_n++;
    end
    checks++;
    if (lv_n != 1 || code_seen !== 2'b01 || sos_n != 0) begin
      failures++; $display("FAIL reset_mid_after got lv=%0d code=%b sos=%0d exp lv=1 code=01 sos=0", lv_n, code_seen, sos_n);
    end
  endtask

  task automatic test_random();
    int k, len;
    stim.delete();
    repeat (250) begin
      k = $urandom_range(0, 3);
      if (k == 0)      len = 3;
      else if (k == 1) len = 3;
      else             len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        if (k == 0)      push(1'b1, 2'b00);
        else if (k == 1) push(1'b1, 2'b11);
        else             push(1'b1, ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11);
        for (int g = $urandom_range(0, 2); g > 0; g--)
          push(1'b1 & ($urandom_range(0, 3) == 0), 2'b01);
      end
      if ($urandom_range(0, 3) == 0) add_idle($urandom_range(GAP - 2, GAP + 3));
      else                            add(" ", 1);
      if ($urandom_range(0, 4) == 0) add(" ", $urandom_range(1, 2));
    end
    add_idle(GAP + 4);
    foreach (stim[i]) begin
      step(stim[i][2], stim[i][1:0]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random step=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    symValid = 1'b0;
    symIn = 2'b00;
    model_reset();
    test_reset();
    test_sos_basic();
    test_overlap();
    test_overflow_spaces();
    test_timeout();
    test_reserved();
    test_back_to_back();
    test_reset_mid_letter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
